// File: rtl/flash_glyph_fetch_if.sv
// Handshake bundle between the glyph fetcher, its pixel requester/consumer and the flash reader.
// The master modport is the surrounding logic; the slave modport is the fetcher.
interface flash_glyph_fetch_if #(
   parameter int CW               = 8,
   parameter int FLASH_WORD_WIDTH = 32,
   parameter int AW               = 30 - $clog2(FLASH_WORD_WIDTH)
);
   logic                        req_valid;
   logic                        req_ready;
   logic [29:0]                 addressOffsetBits;
   logic [CW-1:0]               characterIndex;
   logic                        flash_rd_req;
   logic [AW-1:0]               flash_rd_addr;
   logic                        flash_rd_ack;
   logic                        flash_rd_valid;
   logic [FLASH_WORD_WIDTH-1:0] flash_rd_data;
   logic                        pixel_valid;
   logic                        pixel;
   logic                        pixel_ready;
   logic                        cache_invalidate;

   modport master (
      output req_valid, addressOffsetBits, characterIndex, flash_rd_ack, flash_rd_valid,
             flash_rd_data, pixel_ready, cache_invalidate,
      input  req_ready, flash_rd_req, flash_rd_addr, pixel_valid, pixel
   );

   modport slave (
      input  req_valid, addressOffsetBits, characterIndex, flash_rd_ack, flash_rd_valid,
             flash_rd_data, pixel_ready, cache_invalidate,
      output req_ready, flash_rd_req, flash_rd_addr, pixel_valid, pixel
   );
endinterface

// File: rtl/flash_glyph_fetch.sv
// Fetches one glyph pixel bit from flash, with a single-word cache in front of the flash reader.
//
// state     | meaning
// IDLE      | ready for a pixel request
// ISSUE     | flash_rd_req raised, waiting for flash_rd_ack
// WAIT_DATA | read accepted, waiting for flash_rd_valid
// OUTPUT    | pixel_valid held until pixel_ready
module flash_glyph_fetch #(
   parameter int memFontHeight     = 128,
   parameter int memFontWidth      = 64,
   parameter int charactersPerFont = 256,
   parameter int FLASH_WORD_WIDTH  = 32
) (
   input logic               clk,
   input logic               rst,
   flash_glyph_fetch_if.slave bus
);
   localparam int CW = $clog2(charactersPerFont);
   localparam int WB = $clog2(FLASH_WORD_WIDTH);
   localparam int AW = 30 - WB;
   localparam int SH = $clog2(memFontHeight) + $clog2(memFontWidth);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, OUTPUT} state_t;

   state_t state, next_state;

   logic                        run_q;
   logic [AW-1:0]               addr_q;
   logic [WB-1:0]               bit_q;
   logic [FLASH_WORD_WIDTH-1:0] data_q;
   logic                        no_cache_q;
   logic                        cache_valid;
   logic [AW-1:0]               cache_tag;
   logic [FLASH_WORD_WIDTH-1:0] cache_data;

   logic [29:0]   char_ext;
   logic [29:0]   full_bit;
   logic [AW-1:0] word_cmb;
   logic [WB-1:0] bit_cmb;
   logic          hit;
   logic          accept;
   logic          capture;
   logic          req_ready_c;
   logic          rd_req_c;
   logic          pixel_valid_c;

   assign char_ext = 30'(bus.characterIndex);
   assign full_bit = bus.addressOffsetBits + (char_ext << SH);
   assign word_cmb = full_bit[29:WB];
   assign bit_cmb  = full_bit[WB-1:0];
   // An invalidate in the accepting cycle must not be beaten by the stale entry.
   assign hit = cache_valid && (cache_tag == word_cmb) && !bus.cache_invalidate;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state    = state;
      req_ready_c   = 1'b0;
      rd_req_c      = 1'b0;
      pixel_valid_c = 1'b0;
      accept        = 1'b0;
      capture       = 1'b0;
      case (state)
         IDLE: begin
            req_ready_c = run_q;
            if (bus.req_valid && run_q) begin
               accept     = 1'b1;
               next_state = hit ? OUTPUT : ISSUE;
            end
         end
         ISSUE: begin
            rd_req_c = 1'b1;
            if (bus.flash_rd_ack) begin
               capture    = bus.flash_rd_valid;
               next_state = bus.flash_rd_valid ? OUTPUT : WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            if (bus.flash_rd_valid) begin
               capture    = 1'b1;
               next_state = OUTPUT;
            end
         end
         OUTPUT: begin
            pixel_valid_c = 1'b1;
            if (bus.pixel_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q       <= 1'b0;
         addr_q      <= '0;
         bit_q       <= '0;
         data_q      <= '0;
         no_cache_q  <= 1'b0;
         cache_valid <= 1'b0;
         cache_tag   <= '0;
         cache_data  <= '0;
      end else begin
         run_q <= 1'b1;
         if (accept) begin
            addr_q     <= word_cmb;
            bit_q      <= bit_cmb;
            no_cache_q <= 1'b0;
            if (hit) data_q <= cache_data;
         end
         // A word whose read overlapped an invalidate may already be stale; deliver it but never cache it.
         if (((state == ISSUE) || (state == WAIT_DATA)) && bus.cache_invalidate)
            no_cache_q <= 1'b1;
         if (capture) begin
            data_q <= bus.flash_rd_data;
            if (!no_cache_q && !bus.cache_invalidate) begin
               cache_tag   <= addr_q;
               cache_data  <= bus.flash_rd_data;
               cache_valid <= 1'b1;
            end
         end
         if (bus.cache_invalidate) cache_valid <= 1'b0;
      end
   end

   assign bus.req_ready     = req_ready_c;
   assign bus.flash_rd_req  = rd_req_c;
   assign bus.flash_rd_addr = addr_q;
   assign bus.pixel_valid   = pixel_valid_c;
   assign bus.pixel         = pixel_valid_c & data_q[bit_q];
endmodule

// File: tb/tb_flash_glyph_fetch.sv
// Self-checking bench: table of pixel requests with hand-derived addresses/pixels, a pixel scoreboard,
// and a hand-written reset-during-read sequence.
module tb_flash_glyph_fetch;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   bit   exp_q[$];

   flash_glyph_fetch_if #(.CW(8), .FLASH_WORD_WIDTH(32)) bus ();

   flash_glyph_fetch dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  ch;
      logic [29:0] off;
      logic [31:0] data;
      bit          hit;
      logic [24:0] addr;
      bit          pix;
      int          ack_delay;
      bit          same;
      int          bp;
      bit          inv_before;
      bit          inv_at_accept;
      bit          inv_mid;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t mk(logic [7:0] ch, logic [29:0] off, logic [31:0] data, bit hit,
                               logic [24:0] addr, bit pix, int ack_delay, bit same, int bp,
                               bit inv_before, bit inv_at_accept, bit inv_mid);
      vec_t v;
      v.ch = ch; v.off = off; v.data = data; v.hit = hit; v.addr = addr; v.pix = pix;
      v.ack_delay = ack_delay; v.same = same; v.bp = bp;
      v.inv_before = inv_before; v.inv_at_accept = inv_at_accept; v.inv_mid = inv_mid;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input vec_t v);
      int n;
      logic [24:0] addr0;
      n = 0;
      if (v.inv_before) begin
         bus.cache_invalidate = 1'b1;
         step();
         bus.cache_invalidate = 1'b0;
      end
      while (!bus.req_ready && n < 20) begin
         step();
         n++;
      end
      chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
      exp_q.push_back(v.pix);
      bus.req_valid         = 1'b1;
      bus.characterIndex    = v.ch;
      bus.addressOffsetBits = v.off;
      bus.cache_invalidate  = v.inv_at_accept;
      step();
      bus.req_valid        = 1'b0;
      bus.cache_invalidate = 1'b0;
      chk("req_ready_busy", 64'(bus.req_ready), 64'd0);
      if (v.hit) begin
         chk("hit_no_rd_req", 64'(bus.flash_rd_req), 64'd0);
         chk("hit_pixel_valid", 64'(bus.pixel_valid), 64'd1);
      end else begin
         chk("miss_rd_req", 64'(bus.flash_rd_req), 64'd1);
         chk("miss_rd_addr", 64'(bus.flash_rd_addr), 64'(v.addr));
         addr0 = bus.flash_rd_addr;
         repeat (v.ack_delay) begin
            step();
            chk("issue_req_stable", 64'(bus.flash_rd_req), 64'd1);
            chk("issue_addr_stable", 64'(bus.flash_rd_addr), 64'(addr0));
         end
         bus.flash_rd_ack = 1'b1;
         if (v.same) begin
            bus.flash_rd_valid = 1'b1;
            bus.flash_rd_data  = v.data;
         end
         step();
         bus.flash_rd_ack   = 1'b0;
         bus.flash_rd_valid = 1'b0;
         bus.flash_rd_data  = ~v.data;
         if (!v.same) begin
            chk("wait_no_rd_req", 64'(bus.flash_rd_req), 64'd0);
            chk("wait_no_pixel", 64'(bus.pixel_valid), 64'd0);
            if (v.inv_mid) bus.cache_invalidate = 1'b1;
            step();
            bus.cache_invalidate = 1'b0;
            bus.flash_rd_valid = 1'b1;
            bus.flash_rd_data  = v.data;
            step();
            bus.flash_rd_valid = 1'b0;
            bus.flash_rd_data  = ~v.data;
         end
         chk("miss_pixel_valid", 64'(bus.pixel_valid), 64'd1);
      end
      repeat (v.bp) begin
         step();
         chk("bp_pixel_valid", 64'(bus.pixel_valid), 64'd1);
         chk("bp_pixel", 64'(bus.pixel), 64'(v.pix));
         chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
      end
      bus.pixel_ready = 1'b1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty actual=pixel required=none");
      end else begin
         chk("pixel_valid_out", 64'(bus.pixel_valid), 64'd1);
         chk("pixel", 64'(bus.pixel), 64'(exp_q.pop_front()));
      end
      step();
      bus.pixel_ready = 1'b0;
      chk("pixel_done", 64'(bus.pixel_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0;
      errors = 0;
      //        ch     off           data          hit addr   pix dly same bp ib ia im
      vecs[0]  = mk(8'd2,   30'h41,       32'h0000_0002, 0, 25'd514,   1, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(8'd2,   30'h5E,       32'h0,         1, 25'd514,   0, 0, 0, 0, 0, 0, 0);
      vecs[2]  = mk(8'd1,   30'h3FFFFFFF, 32'h8000_0000, 0, 25'd255,   1, 5, 1, 0, 0, 0, 0);
      vecs[3]  = mk(8'd1,   30'h3FFFFFE0, 32'h0,         1, 25'd255,   0, 0, 0, 0, 0, 0, 0);
      vecs[4]  = mk(8'd0,   30'h20,       32'hFFFF_FFFE, 0, 25'd1,     0, 1, 0, 4, 0, 0, 0);
      vecs[5]  = mk(8'd0,   30'h3F,       32'h0,         1, 25'd1,     1, 0, 0, 2, 0, 0, 0);
      vecs[6]  = mk(8'd255, 30'h5,        32'h0000_0020, 0, 25'd65280, 1, 2, 0, 0, 0, 0, 0);
      vecs[7]  = mk(8'd2,   30'h41,       32'h0000_0002, 0, 25'd514,   1, 0, 1, 0, 0, 0, 0);
      vecs[8]  = mk(8'd2,   30'h5E,       32'h0,         1, 25'd514,   0, 0, 0, 0, 0, 0, 0);
      vecs[9]  = mk(8'd2,   30'h41,       32'h0000_0002, 0, 25'd514,   1, 0, 0, 0, 1, 0, 0);
      vecs[10] = mk(8'd2,   30'h41,       32'h0000_0002, 0, 25'd514,   1, 0, 0, 0, 0, 1, 0);
      vecs[11] = mk(8'd2,   30'h60,       32'h0000_0001, 0, 25'd515,   1, 0, 0, 0, 0, 0, 1);
      vecs[12] = mk(8'd2,   30'h61,       32'h0000_0003, 0, 25'd515,   1, 0, 0, 0, 0, 0, 0);
      vecs[13] = mk(8'd2,   30'h62,       32'h0,         1, 25'd515,   0, 0, 0, 0, 0, 0, 0);

      rst                   = 1'b0;
      bus.req_valid         = 1'b0;
      bus.addressOffsetBits = '0;
      bus.characterIndex    = '0;
      bus.flash_rd_ack      = 1'b0;
      bus.flash_rd_valid    = 1'b0;
      bus.flash_rd_data     = '0;
      bus.pixel_ready       = 1'b0;
      bus.cache_invalidate  = 1'b0;
      #3;
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_rd_req", 64'(bus.flash_rd_req), 64'd0);
      chk("rst_rd_addr", 64'(bus.flash_rd_addr), 64'd0);
      chk("rst_pixel_valid", 64'(bus.pixel_valid), 64'd0);
      chk("rst_pixel", 64'(bus.pixel), 64'd0);
      step();
      step();
      rst = 1'b1;
      chk("release_before_edge", 64'(bus.req_ready), 64'd0);
      step();
      chk("release_after_edge", 64'(bus.req_ready), 64'd1);

      for (int i = 0; i < 14; i++) do_req(vecs[i]);

      // Reset while a read sits in WAIT_DATA: char 3, offset 0 -> word 768.
      bus.req_valid         = 1'b1;
      bus.characterIndex    = 8'd3;
      bus.addressOffsetBits = 30'h0;
      step();
      bus.req_valid = 1'b0;
      chk("rw_rd_addr", 64'(bus.flash_rd_addr), 64'd768);
      bus.flash_rd_ack = 1'b1;
      step();
      bus.flash_rd_ack = 1'b0;
      chk("rw_in_wait", 64'(bus.flash_rd_req), 64'd0);
      rst = 1'b0;
      #1;
      chk("rw_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rw_rd_req", 64'(bus.flash_rd_req), 64'd0);
      chk("rw_rd_addr0", 64'(bus.flash_rd_addr), 64'd0);
      chk("rw_pixel_valid", 64'(bus.pixel_valid), 64'd0);
      chk("rw_pixel", 64'(bus.pixel), 64'd0);
      step();
      rst = 1'b1;
      step();
      chk("rw_req_ready_after", 64'(bus.req_ready), 64'd1);
      bus.flash_rd_valid = 1'b1;
      bus.flash_rd_data  = 32'hFFFF_FFFF;
      step();
      bus.flash_rd_valid = 1'b0;
      repeat (3) begin
         chk("rw_stray_valid", 64'(bus.pixel_valid), 64'd0);
         chk("rw_ready_kept", 64'(bus.req_ready), 64'd1);
         step();
      end
      // Reset emptied the cache, so word 515 must be fetched again.
      do_req(mk(8'd2, 30'h62, 32'h0000_0004, 0, 25'd515, 1, 0, 0, 0, 0, 0, 0));

      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/flash_glyph_fetch.md
FLASH_GLYPH_FETCH -- requirements
Module: flash_glyph_fetch

Interface
REQ-001 SHALL have parameter memFontHeight, default 128, glyph height in flash (pixels), power of 2.
REQ-002 SHALL have parameter memFontWidth, default 64, glyph width in flash (pixels), power of 2.
REQ-003 SHALL have parameter charactersPerFont, default 256, glyphs per font, power of 2; CW = clog2(charactersPerFont).
REQ-004 SHALL have parameter FLASH_WORD_WIDTH, default 32, flash data width, power of 2; WB = clog2(FLASH_WORD_WIDTH).
REQ-005 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 req_valid  in  1  pixel-fetch request present.
REQ-009 req_ready  out  1  block accepts request this cycle.
REQ-010 addressOffsetBits  in  30  font + x + y bit offset (character offset excluded).
REQ-011 characterIndex  in  CW  character code read from RAM.
REQ-012 flash_rd_req  out  1  flash word read request.
REQ-013 flash_rd_addr  out  30-WB  flash word address.
REQ-014 flash_rd_ack  in  1  flash accepted the read request.
REQ-015 flash_rd_valid  in  1  flash_rd_data valid, one-cycle pulse.
REQ-016 flash_rd_data  in  FLASH_WORD_WIDTH  returned flash word.
REQ-017 pixel_valid  out  1  pixel output valid.
REQ-018 pixel  out  1  fetched glyph pixel bit.
REQ-019 pixel_ready  in  1  downstream accepts pixel.
REQ-020 cache_invalidate  in  1  clear cached word (flash contents changed).

Function
REQ-021 Full bit address SHALL be (addressOffsetBits + (characterIndex << (clog2(memFontHeight)+clog2(memFontWidth)))) mod 2^30, computed in the acceptance cycle and registered.
REQ-022 Word address SHALL be fullBit[29:WB]; bit select SHALL be fullBit[WB-1:0]; bit 0 of a flash word is the lowest bit address (LSB-first).
REQ-023 Request SHALL be accepted only when req_valid and req_ready are both 1; req_ready SHALL be 1 only in state IDLE.
REQ-024 States SHALL be IDLE, ISSUE, WAIT_DATA, OUTPUT.
REQ-025 IDLE on accept: cache valid and tag equals word address -> OUTPUT (hit); otherwise -> ISSUE (miss).
REQ-026 ISSUE: flash_rd_req=1 and flash_rd_addr=word address, held stable until flash_rd_ack=1; on ack -> WAIT_DATA.
REQ-027 flash_rd_ack and flash_rd_valid high in the same ISSUE cycle SHALL capture data and go directly to OUTPUT.
REQ-028 WAIT_DATA: on flash_rd_valid, capture word, load cache (tag, data, valid=1), -> OUTPUT.
REQ-029 flash_rd_valid outside ISSUE/WAIT_DATA SHALL be ignored.
REQ-030 OUTPUT: pixel_valid=1, pixel=selected bit, both held stable until pixel_ready=1; then -> IDLE.
REQ-031 Latency: hit -> pixel_valid the cycle after acceptance; miss -> flash_rd_req the cycle after acceptance, pixel_valid the cycle after flash_rd_valid.
REQ-032 cache_invalidate SHALL clear cache valid next edge in any state; if asserted during ISSUE/WAIT_DATA, the returned word is still output but SHALL NOT be cached.
REQ-033 cache_invalidate in the same IDLE cycle as an accepted request SHALL force a miss.
REQ-034 Cache SHALL be a single entry (tag 30-WB bits, data FLASH_WORD_WIDTH bits, valid bit).

Reset
REQ-035 rst=0 SHALL force IDLE, cache valid=0, flash_rd_req=0, flash_rd_addr=0, pixel_valid=0, pixel=0, immediately, regardless of state.
REQ-036 req_ready SHALL be 0 while rst=0 and 1 from the first edge after release.
REQ-037 Reset during ISSUE/WAIT_DATA SHALL abandon the read; a stray flash_rd_valid afterwards SHALL be ignored.

Verification
REQ-038 Miss: characterIndex=2, offset=0x41 -> flash_rd_addr=514; data 0x00000002 -> pixel=1; cache tag 514.
REQ-039 Hit: then characterIndex=2, offset=0x5E -> no flash_rd_req, pixel_valid next cycle, pixel=data bit 30=0.
REQ-040 Wrap: characterIndex=1, offset=0x3FFFFFFF -> fullBit=8191, flash_rd_addr=255, bit select 31.
REQ-041 Handshake: flash_rd_ack held low 5 cycles -> flash_rd_req/addr stable; ack+valid same cycle -> pixel_valid next cycle.
REQ-042 Backpressure/invalidate: pixel_ready low 4 cycles -> pixel held, req_ready=0; cache_invalidate then repeat of REQ-038 request -> flash read reissued.
REQ-043 Reset in WAIT_DATA -> outputs zero, req_ready=1 after release, late flash_rd_valid produces no pixel_valid.
